// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// opcodes, FSM states and datapath select values.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_IMM_EXEC,
        S_IMM_WB
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW   || op == OP_SW
            || op == OP_BEQ   || op == OP_J    || op == OP_ADDI
            || op == OP_ANDI  || op == OP_ORI  || op == OP_SLTI;
    endfunction

    function automatic logic is_zext(input logic [5:0] op);
        return op == OP_ANDI || op == OP_ORI;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: one phase
// per cycle, memory phases stall until mem_ready.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_zero,
    output logic       illegal_op,
    output logic       instr_done
);

    logic [1:0] rst_sync_q;
    state_e     state_q, state_d;
    logic [5:0] opcode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // Async entry to IDLE; exit only once the synchroniser has filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else if (!rst_sync_q[1]) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opcode_q <= opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_SLTI:
                                  state_d = S_IMM_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:
                state_d = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_IMM_WB:
                         state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        ext_zero      = 1'b0;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = !is_legal(opcode);
                instr_done = !is_legal(opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_IMM;
                ext_zero  = is_zext(opcode_q);
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                ext_zero   = is_zext(opcode_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level
// phase-queue model checked every cycle, plus literal spot checks.
module tb_multicycle_control;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] BAD  = 6'b111111;

    localparam logic [18:0] M_PCW  = 19'd1 << 18;
    localparam logic [18:0] M_PWC  = 19'd1 << 17;
    localparam logic [18:0] M_IORD = 19'd1 << 16;
    localparam logic [18:0] M_MRD  = 19'd1 << 15;
    localparam logic [18:0] M_MWR  = 19'd1 << 14;
    localparam logic [18:0] M_IRW  = 19'd1 << 13;
    localparam logic [18:0] M_RDST = 19'd1 << 12;
    localparam logic [18:0] M_M2R  = 19'd1 << 11;
    localparam logic [18:0] M_RW   = 19'd1 << 10;
    localparam logic [18:0] M_SRCA = 19'd1 << 9;
    localparam logic [18:0] M_EZ   = 19'd1 << 2;
    localparam logic [18:0] M_ILL  = 19'd1 << 1;
    localparam logic [18:0] M_DONE = 19'd1;

    typedef struct packed {
        logic [18:0] base;
        logic [18:0] rdy;
        logic        waits;
        logic        dec;
    } phase_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = LW;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       ext_zero, illegal_op, instr_done;
    logic [18:0] dut_v;

    int vecs = 0;
    int errs = 0;
    phase_t plan[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source),
        .ext_zero(ext_zero), .illegal_op(illegal_op),
        .instr_done(instr_done)
    );

    assign dut_v = {pc_write, pc_write_cond, i_or_d, mem_read,
                    mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, ext_zero, illegal_op, instr_done};

    function automatic logic [18:0] srcb(input logic [1:0] v);
        return {10'b0, v, 7'b0};
    endfunction
    function automatic logic [18:0] aop(input logic [1:0] v);
        return {12'b0, v, 5'b0};
    endfunction
    function automatic logic [18:0] psrc(input logic [1:0] v);
        return {14'b0, v, 3'b0};
    endfunction
    function automatic phase_t mk(input logic [18:0] b,
                                  input logic [18:0] r,
                                  input logic w, input logic d);
        phase_t p;
        p.base = b; p.rdy = r; p.waits = w; p.dec = d;
        return p;
    endfunction
    function automatic logic legal(input logic [5:0] op);
        case (op)
            LW, SW, RT, BEQ, JMP, ADDI, ORI,
            6'b001100, 6'b001010: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    // Instruction-level model: a queue of the phases still to run.
    task automatic append_instr(input logic [5:0] op);
        logic z;
        z = (op == 6'b001100) || (op == ORI);
        case (op)
            LW: begin
                plan.push_back(mk(M_SRCA | srcb(2), 0, 0, 0));
                plan.push_back(mk(M_MRD | M_IORD, 0, 1, 0));
                plan.push_back(mk(M_RW | M_M2R | M_DONE, 0, 0, 0));
            end
            SW: begin
                plan.push_back(mk(M_SRCA | srcb(2), 0, 0, 0));
                plan.push_back(mk(M_MWR | M_IORD, M_DONE, 1, 0));
            end
            RT: begin
                plan.push_back(mk(M_SRCA | aop(2), 0, 0, 0));
                plan.push_back(mk(M_RW | M_RDST | M_DONE, 0, 0, 0));
            end
            BEQ: plan.push_back(mk(M_SRCA | aop(1) | M_PWC
                                   | psrc(1) | M_DONE, 0, 0, 0));
            JMP: plan.push_back(mk(M_PCW | psrc(2) | M_DONE, 0, 0, 0));
            ADDI, ORI, 6'b001100, 6'b001010: begin
                plan.push_back(mk(M_SRCA | srcb(2) | aop(3)
                                  | (z ? M_EZ : 19'd0), 0, 0, 0));
                plan.push_back(mk(M_RW | M_DONE
                                  | (z ? M_EZ : 19'd0), 0, 0, 0));
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            plan.delete();
            repeat (3) plan.push_back(mk(0, 0, 0, 0));
        end else if (plan.size() != 0) begin
            phase_t h;
            h = plan[0];
            if (!(h.waits && !mem_ready)) begin
                void'(plan.pop_front());
                if (h.dec) append_instr(opcode);
                if (plan.size() == 0) begin
                    plan.push_back(mk(M_MRD | srcb(1),
                                      M_IRW | M_PCW, 1, 0));
                    plan.push_back(mk(srcb(3), 0, 0, 1));
                end
            end
        end
    end

    initial forever begin
        logic [18:0] exp_v;
        @(negedge clk);
        exp_v = 19'd0;
        if (plan.size() != 0) begin
            exp_v = plan[0].base | (mem_ready ? plan[0].rdy : 19'd0);
            if (plan[0].dec && !legal(opcode))
                exp_v = exp_v | M_ILL | M_DONE;
        end
        vecs++;
        if (dut_v !== exp_v) begin
            errs++;
            $display("FAIL model t=%0t: got %05h want %05h",
                     $time, dut_v, exp_v);
        end
    end

    task automatic chk(input string nm, input logic [18:0] act,
                       input logic [18:0] exp_v);
        vecs++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got %05h want %05h", nm, act, exp_v);
        end
    endtask

    task automatic tick(input logic [5:0] op, input logic rdy);
        @(posedge clk);
        #1;
        opcode = op;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk("reset_zero", dut_v, 19'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("idle_release", dut_v, 19'd0);
        repeat (2) tick(LW, 1'b1);
        tick(LW, 1'b1);
        chk("lw_fetch", dut_v & (M_MRD | M_IRW | M_PCW),
            M_MRD | M_IRW | M_PCW);
        tick(LW, 1'b1);
        tick(LW, 1'b1);
        chk("lw_addr", dut_v & (M_SRCA | srcb(3)), M_SRCA | srcb(2));
        tick(LW, 1'b1);
        chk("lw_read", dut_v & (M_RW | M_MRD | M_IORD), M_MRD | M_IORD);
        tick(LW, 1'b1);
        chk("lw_wb", dut_v & (M_RW | M_M2R | M_DONE),
            M_RW | M_M2R | M_DONE);

        tick(SW, 1'b1);
        tick(SW, 1'b1);
        tick(LW, 1'b1);
        tick(LW, 1'b0);
        chk("sw_stall", dut_v & (M_MWR | M_DONE), M_MWR);
        tick(LW, 1'b0);
        tick(LW, 1'b0);
        tick(LW, 1'b1);
        chk("sw_done", dut_v & (M_MWR | M_DONE), M_MWR | M_DONE);

        tick(ORI, 1'b0);
        chk("fetch_stall", dut_v & (M_MRD | M_IRW | M_PCW), M_MRD);
        tick(ORI, 1'b1);
        tick(ORI, 1'b0);
        tick(ADDI, 1'b1);
        chk("ori_exec", dut_v & (M_EZ | aop(3) | srcb(3)),
            M_EZ | aop(3) | srcb(2));
        tick(ADDI, 1'b1);
        chk("ori_wb", dut_v & (M_EZ | M_RW | M_DONE),
            M_EZ | M_RW | M_DONE);

        repeat (2) tick(ADDI, 1'b1);
        tick(ADDI, 1'b1);
        chk("addi_exec", dut_v & (M_EZ | aop(3) | srcb(3)),
            aop(3) | srcb(2));
        tick(ADDI, 1'b1);

        repeat (2) tick(BEQ, 1'b1);
        tick(BEQ, 1'b1);
        chk("beq", dut_v & (M_PWC | aop(3) | psrc(3) | M_DONE),
            M_PWC | aop(1) | psrc(1) | M_DONE);

        repeat (2) tick(JMP, 1'b1);
        tick(JMP, 1'b1);
        chk("jump", dut_v & (M_PCW | psrc(3)), M_PCW | psrc(2));

        repeat (3) tick(RT, 1'b1);
        tick(RT, 1'b1);
        chk("rtype_wb", dut_v & (M_RW | M_RDST | M_DONE),
            M_RW | M_RDST | M_DONE);

        tick(BAD, 1'b1);
        tick(BAD, 1'b1);
        chk("illegal", dut_v & (M_ILL | M_DONE | M_RW | M_MWR),
            M_ILL | M_DONE);
        tick(LW, 1'b1);
        chk("illegal_next", dut_v & (M_ILL | M_MRD), M_MRD);

        tick(LW, 1'b1);
        tick(LW, 1'b1);
        tick(LW, 1'b0);
        tick(LW, 1'b0);
        tick(LW, 1'b1);
        tick(LW, 1'b1);
        chk("wb_pre_rst", dut_v & M_RW, M_RW);
        #1 rst_n = 1'b0;
        #1 chk("wb_rst_async", dut_v, 19'd0);
        tick(LW, 1'b1);
        tick(LW, 1'b1);
        rst_n = 1'b1;
        #1 chk("rst_idle", dut_v, 19'd0);
        repeat (2) tick(LW, 1'b1);
        tick(LW, 1'b1);
        chk("rst_fetch", dut_v & M_MRD, M_MRD);
        repeat (5) tick(LW, 1'b1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences instruction execution one phase per cycle. It drives every datapath select and strobe: PC, instruction/data memory, register file, ALU source muxes, and the immediate extender's sign/zero mode. A ready handshake stalls the FSM on any memory access.

## Interface
- No parameters; opcode and state encodings come from the shared package.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the IR; sampled in DECODE
- mem_ready  in  1  memory completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = extended imm, 11 = extended imm << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct, 11 = use opcode (immediate ALU ops)
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ext_zero  out  1  immediate extender mode: 0 = sign-extend, 1 = zero-extend
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB.
- Outputs are combinational from the state (Moore), except the strobes gated by mem_ready where stated.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode:
    - 000000 → EXECUTE
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 / 001100 / 001101 / 001010 (addi/andi/ori/slti) → IMM_EXEC
    - any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00, ext_zero=0.
  - Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1.
  - instr_done equals mem_ready.
  - Waits for mem_ready, then goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- IMM_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=11.
  - ext_zero=1 for andi/ori, 0 for addi/slti.
  - Next state IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. ext_zero is held at its IMM_EXEC value. Next state FETCH.
- The opcode used for the lw/sw split and for ext_zero is a 6-bit copy latched in DECODE. The IR may change without affecting an instruction in flight.

## Timing
- Reset: while rst_n=0 the state is IDLE, all outputs are 0, and the latched opcode is 000000.
- Reset is asserted asynchronously and released synchronously (two-flop synchroniser on rst_n deassertion).
- Cycle counts with zero wait states (mem_ready always 1):
  - lw: 5
  - sw, R-type, I-type ALU: 4
  - beq, j: 3
  - illegal opcode: 2
- Each cycle that mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. The request signals are held steady throughout the stall.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- Reset asserted mid-instruction: state goes to IDLE immediately and all strobes drop in the same cycle. No partial register or memory write may complete afterwards.

## Structure
- Package mips_ctrl_pkg holds:
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - the state enumeration
  - the alu_op, alu_src_b and pc_source encodings.
- The module is a single FSM with no sub-modules: one state register, one next-state block and one output decode block.

## Test plan
- Reset, then opcode=100011 with mem_ready=1 → state sequence IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. reg_write=1 and mem_to_reg=1 only in MEM_WB; instr_done fires at cycle 5.
- opcode=101011 with mem_ready low for 3 cycles in MEM_WRITE → mem_write held for 4 cycles; instr_done appears only in the mem_ready=1 cycle.
- opcode=001101 → ext_zero=1 in IMM_EXEC and IMM_WB, with alu_op=11 and alu_src_b=10. Repeat with 001000 → ext_zero=0.
- opcode=000100 → pc_write_cond=1, alu_op=01, pc_source=01 in cycle 3. opcode=000010 → pc_write=1, pc_source=10 in cycle 3.
- opcode=111111 → illegal_op pulses for one cycle in DECODE, the next state is FETCH, and no reg_write or mem_write occurs.
- rst_n pulled low during MEM_WB → reg_write drops asynchronously; after release the FSM goes IDLE, then FETCH.
